// File: rtl/matrix_host_controller.sv
// Host-side controller for a matrix multiply unit.
// Collects two operands as 4-bit nibbles (LSB nibble first), pulses the
// multiply unit, waits (bounded) for its done strobe, then streams the
// result back out as nibbles, LSB nibble first.
module matrix_host_controller #(
    parameter int NIBBLES = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [3:0]             in_nibble,
    output logic                   in_ready,
    output logic                   mm_enable,
    output logic [4*NIBBLES-1:0]   mm_matrixA,
    output logic [4*NIBBLES-1:0]   mm_matrixB,
    input  logic [4*NIBBLES-1:0]   mm_result,
    input  logic                   mm_listo,
    output logic                   out_valid,
    output logic [3:0]             out_nibble,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   err
);

    localparam int W  = 4 * NIBBLES;
    localparam int NW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [NW-1:0] NIB_LAST  = NW'(NIBBLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    localparam logic [2:0] ST_LOAD_A = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;

    logic [2:0]    state_q,   state_d;
    logic [NW-1:0] nib_cnt_q, nib_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [W-1:0]  mat_a_q,   mat_a_d;
    logic [W-1:0]  mat_b_q,   mat_b_d;
    logic [W-1:0]  shift_q,   shift_d;
    logic          err_q,     err_d;

    logic               accept;
    logic               nib_last;
    logic [NIBBLES-1:0] nib_sel;

    // One-hot select of the operand nibble slot addressed by the nibble counter
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib_sel
        assign nib_sel[gi] = (nib_cnt_q == NW'(gi));
    end

    assign in_ready   = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign accept     = in_valid && in_ready;
    assign nib_last   = (nib_cnt_q == NIB_LAST);
    assign mm_enable  = (state_q == ST_START);
    assign busy       = (state_q == ST_START) || (state_q == ST_WAIT) || (state_q == ST_SEND);
    assign out_valid  = (state_q == ST_SEND);
    assign out_nibble = shift_q[3:0];
    assign mm_matrixA = mat_a_q;
    assign mm_matrixB = mat_b_q;
    assign err        = err_q;

    // Next-state logic: operand loading, start pulse, bounded wait, result streaming
    always_comb begin
        state_d    = state_q;
        nib_cnt_d  = nib_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mat_a_d    = mat_a_q;
        mat_b_d    = mat_b_q;
        shift_d    = shift_q;
        err_d      = err_q;

        case (state_q)
            ST_LOAD_A: begin
                if (accept) begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (nib_sel[i]) mat_a_d[4*i +: 4] = in_nibble;
                    end
                    // A fresh A operand starting clears a previous timeout
                    if (nib_cnt_q == '0) err_d = 1'b0;
                    if (nib_last) begin
                        nib_cnt_d = '0;
                        state_d   = ST_LOAD_B;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                    end
                end
            end
            ST_LOAD_B: begin
                if (accept) begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (nib_sel[i]) mat_b_d[4*i +: 4] = in_nibble;
                    end
                    if (nib_last) begin
                        nib_cnt_d = '0;
                        state_d   = ST_START;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A done strobe wins over a timeout landing on the same cycle
                if (mm_listo) begin
                    shift_d   = mm_result;
                    nib_cnt_d = '0;
                    state_d   = ST_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        err_d     = 1'b1;
                        nib_cnt_d = '0;
                        state_d   = ST_LOAD_A;
                    end
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    shift_d = {4'b0000, shift_q[W-1:4]};
                    if (nib_last) begin
                        nib_cnt_d = '0;
                        state_d   = ST_LOAD_A;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                nib_cnt_d = '0;
                state_d   = ST_LOAD_A;
            end
        endcase
    end

    // State registers; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD_A;
            nib_cnt_q  <= '0;
            wait_cnt_q <= '0;
            mat_a_q    <= '0;
            mat_b_q    <= '0;
            shift_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nib_cnt_q  <= nib_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
            shift_q    <= shift_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_matrix_host_controller.sv
// Self-checking bench for matrix_host_controller: directed scenarios plus
// randomized transactions, checked against a transaction-level model.
module tb_matrix_host_controller;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_nibble = 4'h0;
    logic        in_ready;
    logic        mm_enable;
    logic [15:0] mm_matrixA;
    logic [15:0] mm_matrixB;
    logic [15:0] mm_result = 16'h0;
    logic        mm_listo = 1'b0;
    logic        out_valid;
    logic [3:0]  out_nibble;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;
    logic exp_err   = 1'b0;

    matrix_host_controller #(.NIBBLES(4), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_nibble  (in_nibble),
        .in_ready   (in_ready),
        .mm_enable  (mm_enable),
        .mm_matrixA (mm_matrixA),
        .mm_matrixB (mm_matrixB),
        .mm_result  (mm_result),
        .mm_listo   (mm_listo),
        .out_valid  (out_valid),
        .out_nibble (out_nibble),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction. Operands are sent LSB nibble first; the responder
    // raises mm_listo `delay` cycles after the mm_enable cycle (delay beyond
    // TIMEOUT means never). mode: 0 out_ready high, 1 toggling from 0, 2 random.
    task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int delay,
                           input logic [15:0] res, input int mode, input bit gaps);
        logic [3:0] nib;
        int last;
        int k;
        int budget;
        logic ord;

        chk("pre_err", 32'(err), 32'(exp_err));
        for (int i = 0; i < 8; i++) begin
            while (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_nibble = 4'($urandom);
                mm_listo = (i >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
            end
            nib = (i < 4) ? 4'((a >> (4 * i)) & 16'hF) : 4'((b >> (4 * (i - 4))) & 16'hF);
            in_valid  = 1'b1;
            in_nibble = nib;
            mm_listo  = (i >= 4 && gaps) ? 1'($urandom_range(0, 1)) : 1'b0;
            chk("load_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 0) begin
                exp_err = 1'b0;
                chk("err_clear", 32'(err), 32'd0);
            end
        end

        // Cycle after the eighth accept: the start pulse
        in_valid = 1'($urandom_range(0, 1));
        in_nibble = 4'($urandom);
        chk("enable", 32'(mm_enable), 32'd1);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_ready", 32'(in_ready), 32'd0);
        chk("mat_a", 32'(mm_matrixA), 32'(a));
        chk("mat_b", 32'(mm_matrixB), 32'(b));

        last = (delay <= TIMEOUT) ? delay : TIMEOUT;
        for (int t = 1; t <= last; t++) begin
            tick();
            chk("enable_once", 32'(mm_enable), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_ready", 32'(in_ready), 32'd0);
            chk("wait_err", 32'(err), 32'd0);
            chk("wait_oval", 32'(out_valid), 32'd0);
            mm_listo  = (t == delay);
            mm_result = (t == delay) ? res : 16'($urandom);
            in_valid  = 1'($urandom_range(0, 1));
            in_nibble = 4'($urandom);
        end
        tick();
        mm_listo = 1'b0;

        if (delay > TIMEOUT) begin
            in_valid = 1'b0;
            exp_err  = 1'b1;
            chk("to_err", 32'(err), 32'd1);
            chk("to_ready", 32'(in_ready), 32'd1);
            chk("to_busy", 32'(busy), 32'd0);
            chk("to_oval", 32'(out_valid), 32'd0);
            return;
        end

        k = 0;
        budget = 0;
        ord = 1'b0;
        while (k < 4 && budget < 100) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin out_ready = ord; ord = ~ord; end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            in_valid  = 1'($urandom_range(0, 1));
            in_nibble = 4'($urandom);
            mm_listo  = 1'($urandom_range(0, 1));
            chk("send_oval", 32'(out_valid), 32'd1);
            chk("send_nib", 32'(out_nibble), 32'((res >> (4 * k)) & 16'hF));
            chk("send_busy", 32'(busy), 32'd1);
            chk("send_ready", 32'(in_ready), 32'd0);
            if (out_ready) k++;
            tick();
            budget++;
        end
        if (k < 4) chk("send_budget", 32'(k), 32'd4);
        in_valid  = 1'b0;
        mm_listo  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        chk("done_oval", 32'(out_valid), 32'd0);
        chk("done_ready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        chk("hold_a", 32'(mm_matrixA), 32'(a));
        chk("hold_b", 32'(mm_matrixB), 32'(b));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_en"}, 32'(mm_enable), 32'd0);
        chk({tag, "_oval"}, 32'(out_valid), 32'd0);
        chk({tag, "_onib"}, 32'(out_nibble), 32'd0);
        chk({tag, "_a"}, 32'(mm_matrixA), 32'd0);
        chk({tag, "_b"}, 32'(mm_matrixB), 32'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst0");
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Streaming load with in_valid held high, then BEEF result
        run_txn(16'h4321, 16'h8765, 23, 16'hBEEF, 0, 1'b0);
        // Same with out_ready toggling
        run_txn(16'h4321, 16'h8765, 23, 16'hBEEF, 1, 1'b0);
        // Responder never answers: timeout
        run_txn(16'h1234, 16'h5678, 1000, 16'h0000, 0, 1'b1);
        // Done strobe on the timeout cycle itself; err cleared by new A
        run_txn(16'hA5C3, 16'h0FF0, TIMEOUT, 16'hC0DE, 2, 1'b1);
        // Boundary delays
        run_txn(16'hFFFF, 16'h0000, 1, 16'h1357, 0, 1'b1);
        run_txn(16'h0001, 16'h8000, TIMEOUT - 1, 16'h2468, 2, 1'b1);
        run_txn(16'h7777, 16'h3333, TIMEOUT + 1, 16'hFFFF, 0, 1'b1);

        // Reset after 5 accepted nibbles
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_nibble = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values("rst1");
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
        run_txn(16'h9999, 16'($urandom), 5, 16'($urandom), 0, 1'b0);

        // Randomized transactions
        for (int n = 0; n < 20; n++) begin
            run_txn(16'($urandom), 16'($urandom), int'($urandom_range(1, TIMEOUT + 8)),
                    16'($urandom), int'($urandom_range(0, 2)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matrix_host_controller.md
MATRIX_HOST_CONTROLLER -- requirements
Module: matrix_host_controller

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning 4-bit nibbles per 16-bit operand or result word.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning maximum cycles spent in WAIT for mm_listo.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream nibble valid.
REQ-006 SHALL have port in_nibble  input  4  upstream nibble data.
REQ-007 SHALL have port in_ready  output  1  controller accepts a nibble this cycle.
REQ-008 SHALL have port mm_enable  output  1  start pulse to the matrix multiply unit.
REQ-009 SHALL have port mm_matrixA  output  16  operand A to the multiply unit.
REQ-010 SHALL have port mm_matrixB  output  16  operand B to the multiply unit.
REQ-011 SHALL have port mm_result  input  16  result from the multiply unit.
REQ-012 SHALL have port mm_listo  input  1  done strobe from the multiply unit.
REQ-013 SHALL have port out_valid  output  1  result nibble valid downstream.
REQ-014 SHALL have port out_nibble  output  4  result nibble data.
REQ-015 SHALL have port out_ready  input  1  downstream accepts a nibble.
REQ-016 SHALL have port busy  output  1  high in START, WAIT and SEND.
REQ-017 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement states LOAD_A, LOAD_B, START, WAIT and SEND, plus a nibble counter (0..NIBBLES-1) and a wait counter (0..TIMEOUT).
REQ-019 SHALL drive in_ready=1 only in LOAD_A and LOAD_B; a nibble is accepted on a cycle with in_valid and in_ready both high.
REQ-020 SHALL write accepted nibble n (n = 0..3) into operand bits [4n+3:4n], so the first nibble lands at bits [3:0]; writes go to A in LOAD_A and to B in LOAD_B.
REQ-021 SHALL, on the 4th accepted nibble, reset the nibble counter to 0 and move LOAD_A->LOAD_B or LOAD_B->START.
REQ-022 SHALL hold mm_matrixA and mm_matrixB stable from START until the next LOAD_A write.
REQ-023 SHALL assert mm_enable for exactly one cycle, in START; START->WAIT unconditionally; the wait counter clears on WAIT entry.
REQ-024 SHALL, in WAIT when mm_listo=1, capture mm_result into a 16-bit output shift register and go to SEND; this has priority over timeout when both occur on the same cycle.
REQ-025 SHALL increment the wait counter once per WAIT cycle without mm_listo.
REQ-026 SHALL, when the wait counter reaches TIMEOUT, set err=1 and go to LOAD_A with the nibble counter cleared and no output produced.
REQ-027 SHALL ignore mm_listo in every state except WAIT.
REQ-028 SHALL, in SEND, drive out_valid=1 and out_nibble=shift[3:0]; both are held stable while out_ready=0.
REQ-029 SHALL, on each SEND cycle with out_valid and out_ready both high, shift right by 4; after the 4th transfer it clears out_valid and goes to LOAD_A.
REQ-030 SHALL clear err when the first nibble of a new A operand is accepted.
REQ-031 SHALL never accept input while busy=1; in_valid in those states is ignored without stall side effects.

Reset
REQ-032 SHALL, on rst=1 (asynchronous, active-high), immediately set: state LOAD_A, both counters 0, mm_matrixA/mm_matrixB/shift register 16'h0000, mm_enable 0, out_valid 0, out_nibble 0, in_ready 1 (combinational), busy 0, err 0.
REQ-033 SHALL abandon any transaction interrupted by reset (mid-load, WAIT or SEND) with no further output; the next nibble after release is treated as A nibble 0.

Verification
REQ-034 SHALL pass this scenario: stream nibbles 1,2,3,4 then 5,6,7,8 with in_valid held high -> mm_matrixA=16'h4321, mm_matrixB=16'h8765, single-cycle mm_enable on the cycle after the 8th accept.
REQ-035 SHALL pass this scenario: a responder model asserts mm_listo 23 cycles after mm_enable with mm_result=16'hBEEF, out_ready=1 -> out_nibble sequence F,E,E,B on 4 consecutive cycles, then in_ready=1.
REQ-036 SHALL pass this scenario: same as REQ-035 but out_ready toggled 0/1 each cycle -> same F,E,E,B sequence, each nibble held while out_ready=0.
REQ-037 SHALL pass this scenario: responder never asserts mm_listo -> err=1 exactly 64 cycles after WAIT entry, state back in LOAD_A; err clears on the next accepted nibble.
REQ-038 SHALL pass this scenario: assert rst after 5 nibbles accepted -> outputs take reset values that cycle; new nibbles 9,9,9,9 give mm_matrixA=16'h9999.
REQ-039 SHALL pass this scenario: mm_listo pulsed during LOAD_B, and mm_listo coincident with the timeout cycle -> the first is ignored; the second captures the result, goes to SEND, and leaves err=0.
